ysyx_23060059_clint: RTL

- AXI4 responder implementing the core-local timer (CLINT mtime), attached to the crossbar's A-side (CLINT) downstream port.
- Free-running 64-bit mtime counter, readable as two 32-bit words at CLINT_L / CLINT_H.
- Independent read and write channel FSMs; all responses are registered.

---
 rtl/ysyx_23060059_clint_pkg.sv | 17 +
 rtl/ysyx_23060059_clint_mtime.sv | 58 +++++
 rtl/ysyx_23060059_clint.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/ysyx_23060059_clint_pkg.sv
// Shared CLINT constants: mtime word addresses, AXI response codes,
// and an address-hit helper used by both channel FSMs.
package ysyx_23060059_clint_pkg;

  localparam logic [31:0] YSYX_23060059_CLINT_L = 32'h0200_BFF8;
  localparam logic [31:0] YSYX_23060059_CLINT_H = 32'h0200_BFFC;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // True when the address selects one of the two mtime words.
  function automatic logic clint_hit(input logic [31:0] addr);
    return (addr == YSYX_23060059_CLINT_L) || (addr == YSYX_23060059_CLINT_H);
  endfunction

endpackage

// File: rtl/ysyx_23060059_clint_mtime.sv
// 64-bit free-running mtime with a tick divider and a byte-merged
// 32-bit write port. A write in the same cycle as a tick wins and the
// tick's increment is dropped.
module ysyx_23060059_clint_mtime #(
  parameter int TICK_DIV = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        wr_en,
  input  logic        wr_hi,
  input  logic [31:0] wr_data,
  input  logic [3:0]  wr_strb,
  output logic [63:0] mtime
);

  logic [15:0] tick_cnt_reg;
  logic [63:0] mtime_reg;
  logic        tick;
  logic [31:0] half_cur;
  logic [31:0] half_next;

  assign tick     = (tick_cnt_reg == 16'(TICK_DIV - 1));
  assign half_cur = wr_hi ? mtime_reg[63:32] : mtime_reg[31:0];

  // Per-byte merge of the incoming lane into the selected half.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_merge
      assign half_next[gi*8 +: 8] = wr_strb[gi] ? wr_data[gi*8 +: 8] : half_cur[gi*8 +: 8];
    end
  endgenerate

  // Divider counts 0..TICK_DIV-1 and wraps on the tick cycle.
  always_ff @(posedge clock) begin
    if (!reset) begin
      tick_cnt_reg <= '0;
    end else if (tick) begin
      tick_cnt_reg <= '0;
    end else begin
      tick_cnt_reg <= tick_cnt_reg + 16'd1;
    end
  end

  // mtime update: write has priority over the tick increment.
  always_ff @(posedge clock) begin
    if (!reset) begin
      mtime_reg <= '0;
    end else if (wr_en) begin
      if (wr_hi) mtime_reg[63:32] <= half_next;
      else       mtime_reg[31:0]  <= half_next;
    end else if (tick) begin
      mtime_reg <= mtime_reg + 64'd1;
    end
  end

  assign mtime = mtime_reg;

endmodule

// File: rtl/ysyx_23060059_clint.sv
// CLINT mtime AXI4 responder. Read and write channels run independent
// FSMs with registered responses. Define YSYX_23060059_CLINT_WRITE_EN
// to make mtime writable; otherwise every write is answered SLVERR.
module ysyx_23060059_clint
  import ysyx_23060059_clint_pkg::*;
#(
  parameter int TICK_DIV = 1,
  parameter int ID_W     = 4
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [31:0]     araddr,
  input  logic            arvalid,
  input  logic [ID_W-1:0] arid,
  input  logic [7:0]      arlen,
  input  logic [2:0]      arsize,
  input  logic [1:0]      arburst,
  output logic            arready,
  input  logic            rready,
  output logic [63:0]     rdata,
  output logic            rvalid,
  output logic [1:0]      rresp,
  output logic [ID_W-1:0] rid,
  output logic            rlast,
  input  logic [31:0]     awaddr,
  input  logic            awvalid,
  input  logic [ID_W-1:0] awid,
  input  logic [7:0]      awlen,
  input  logic [2:0]      awsize,
  input  logic [1:0]      awburst,
  output logic            awready,
  input  logic [63:0]     wdata,
  input  logic [7:0]      wstrb,
  input  logic            wvalid,
  input  logic            wlast,
  output logic            wready,
  input  logic            bready,
  output logic            bvalid,
  output logic [1:0]      bresp,
  output logic [ID_W-1:0] bid
);

  localparam logic [0:0] R_IDLE = 1'b0;
  localparam logic [0:0] R_DATA = 1'b1;
  localparam logic [1:0] W_IDLE = 2'd0;
  localparam logic [1:0] W_DATA = 2'd1;
  localparam logic [1:0] W_RESP = 2'd2;

  logic [0:0]      r_state_reg;
  logic            arready_reg, rvalid_reg, rlast_reg;
  logic [63:0]     rdata_reg;
  logic [1:0]      rresp_reg;
  logic [ID_W-1:0] rid_reg;
  logic [7:0]      rcnt_reg;

  logic [1:0]      w_state_reg;
  logic [31:0]     awaddr_reg;
  logic            awready_reg, wready_reg, bvalid_reg;
  logic [1:0]      bresp_reg;
  logic [ID_W-1:0] bid_reg;

  logic [63:0] mtime;
  logic        wr_en;
  logic        wr_hi;
  logic [31:0] wr_data;
  logic [3:0]  wr_strb;
  logic [1:0]  w_resp_code;

  // Burst type/size and awlen do not affect a fixed-address register target.
  logic unused_sigs;
  assign unused_sigs = ^{arsize, arburst, awsize, awburst, awlen};

  assign wr_hi   = (awaddr_reg == YSYX_23060059_CLINT_H);
  assign wr_data = awaddr_reg[2] ? wdata[63:32] : wdata[31:0];
  assign wr_strb = awaddr_reg[2] ? wstrb[7:4]   : wstrb[3:0];

`ifdef YSYX_23060059_CLINT_WRITE_EN
  assign wr_en       = wready_reg && wvalid && clint_hit(awaddr_reg);
  assign w_resp_code = clint_hit(awaddr_reg) ? RESP_OKAY : RESP_DECERR;
`else
  assign wr_en       = 1'b0;
  assign w_resp_code = RESP_SLVERR;
`endif

  ysyx_23060059_clint_mtime #(.TICK_DIV(TICK_DIV)) u_mtime (
    .clock   (clock),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_hi   (wr_hi),
    .wr_data (wr_data),
    .wr_strb (wr_strb),
    .mtime   (mtime)
  );

  // Read channel: snapshot the selected half at AR and replay it every beat.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state_reg <= R_IDLE;
      arready_reg <= 1'b1;
      rvalid_reg  <= 1'b0;
      rlast_reg   <= 1'b0;
      rdata_reg   <= '0;
      rresp_reg   <= RESP_OKAY;
      rid_reg     <= '0;
      rcnt_reg    <= '0;
    end else begin
      case (r_state_reg)
        R_IDLE: begin
          if (arvalid) begin
            arready_reg <= 1'b0;
            rvalid_reg  <= 1'b1;
            rid_reg     <= arid;
            rcnt_reg    <= arlen;
            rlast_reg   <= (arlen == 8'd0);
            r_state_reg <= R_DATA;
            if (araddr == YSYX_23060059_CLINT_L) begin
              rdata_reg <= {mtime[31:0], mtime[31:0]};
              rresp_reg <= RESP_OKAY;
            end else if (araddr == YSYX_23060059_CLINT_H) begin
              rdata_reg <= {mtime[63:32], mtime[63:32]};
              rresp_reg <= RESP_OKAY;
            end else begin
              rdata_reg <= '0;
              rresp_reg <= RESP_DECERR;
            end
          end
        end
        R_DATA: begin
          if (rready) begin
            if (rlast_reg) begin
              rvalid_reg  <= 1'b0;
              rlast_reg   <= 1'b0;
              arready_reg <= 1'b1;
              r_state_reg <= R_IDLE;
            end else begin
              rcnt_reg  <= rcnt_reg - 8'd1;
              rlast_reg <= (rcnt_reg == 8'd1);
            end
          end
        end
        default: r_state_reg <= R_IDLE;
      endcase
    end
  end

  // Write channel: accept address, swallow beats until wlast, then respond.
  always_ff @(posedge clock) begin
    if (!reset) begin
      w_state_reg <= W_IDLE;
      awaddr_reg  <= '0;
      awready_reg <= 1'b1;
      wready_reg  <= 1'b0;
      bvalid_reg  <= 1'b0;
      bresp_reg   <= RESP_OKAY;
      bid_reg     <= '0;
    end else begin
      case (w_state_reg)
        W_IDLE: begin
          if (awvalid) begin
            awaddr_reg  <= awaddr;
            bid_reg     <= awid;
            awready_reg <= 1'b0;
            wready_reg  <= 1'b1;
            w_state_reg <= W_DATA;
          end
        end
        W_DATA: begin
          if (wvalid && wlast) begin
            wready_reg  <= 1'b0;
            bvalid_reg  <= 1'b1;
            bresp_reg   <= w_resp_code;
            w_state_reg <= W_RESP;
          end
        end
        W_RESP: begin
          if (bready) begin
            bvalid_reg  <= 1'b0;
            awready_reg <= 1'b1;
            w_state_reg <= W_IDLE;
          end
        end
        default: w_state_reg <= W_IDLE;
      endcase
    end
  end

  assign arready = arready_reg;
  assign rvalid  = rvalid_reg;
  assign rlast   = rlast_reg;
  assign rdata   = rdata_reg;
  assign rresp   = rresp_reg;
  assign rid     = rid_reg;
  assign awready = awready_reg;
  assign wready  = wready_reg;
  assign bvalid  = bvalid_reg;
  assign bresp   = bresp_reg;
  assign bid     = bid_reg;

endmodule
